// File: rtl/uart_fifo.sv
// UART with TX and RX FIFOs: 8N1-style framing, optional parity, sticky error flags.
// Latency: tx falls one clock after a byte lands in an empty TX FIFO; RX bytes appear one clock after the stop-bit sample.
// Backpressure: tx_wr ignored while tx_full, rx_rd ignored while rx_empty; received bytes dropped (overrun) when RX FIFO is full.

// Show-ahead circular buffer; extra pointer MSB distinguishes full from empty.
module uart_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         push;
    logic         pop;

    // Occupancy flags and guarded push/pop
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push     = wr && !full;
        pop      = rd && !empty;
        wr_ptr_d = push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
        rdata    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
endmodule

module uart_fifo #(
    parameter int CLK_DIV    = 868,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_wr,
    output logic                 tx_full,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_rd,
    output logic                 rx_empty,
    output logic                 busy,
    output logic [2:0]           err,
    input  logic                 err_clr
);
    localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF     = 16'(CLK_DIV / 2);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic        PEN      = (PARITY_EN != 0);
    localparam logic        ODD      = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ---------------- TX path ----------------
    state_t                 tx_state_q, tx_state_d;
    logic [15:0]            tx_cnt_q, tx_cnt_d;
    logic [2:0]             tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_par_q, tx_par_d;
    logic                   tx_q, tx_d;
    logic                   tx_pop;
    logic                   tx_empty;
    logic [DATA_BITS-1:0]   tx_head;
    logic                   tx_bit_end;

    uart_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (tx_wr),
        .wdata (tx_data),
        .rd    (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign tx_bit_end = (tx_cnt_q == DIV_M1);

    // TX next state; STOP chains straight into START so queued frames leave without a gap
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            S_IDLE:   if (!tx_empty) tx_state_d = S_START;
            S_START:  if (tx_bit_end) tx_state_d = S_DATA;
            S_DATA:   if (tx_bit_end && tx_bit_q == LAST_BIT) tx_state_d = PEN ? S_PARITY : S_STOP;
            S_PARITY: if (tx_bit_end) tx_state_d = S_STOP;
            S_STOP:   if (tx_bit_end) tx_state_d = tx_empty ? S_IDLE : S_START;
            default:  tx_state_d = S_IDLE;
        endcase
    end

    // TX datapath: bit timer, shifter, FIFO pop on frame load, registered line level
    always_comb begin
        tx_pop     = 1'b0;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_cnt_d   = (tx_state_q == S_IDLE || tx_bit_end) ? 16'd0 : tx_cnt_q + 16'd1;
        if (tx_state_d == S_START && tx_state_q != S_START) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_par_d   = (^tx_head) ^ ODD;
            tx_bit_d   = 3'd0;
        end else if (tx_state_q == S_DATA && tx_bit_end) begin
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 3'd1;
        end
        case (tx_state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = tx_shift_d[0];
            S_PARITY: tx_d = tx_par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // TX state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (tx_state_q != S_IDLE) || !tx_empty;

    // ---------------- RX path ----------------
    state_t                 rx_state_q, rx_state_d;
    logic [15:0]            rx_cnt_q, rx_cnt_d;
    logic [2:0]             rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_par_q, rx_par_d;
    logic                   rx_push_q, rx_push_d;
    logic [DATA_BITS-1:0]   rx_byte_q, rx_byte_d;
    logic                   sync1_q, sync2_q, rx_prev_q;
    logic [2:0]             err_q, err_d;
    logic                   rx_full;
    logic                   rx_sample;
    logic                   rx_bit_end;
    logic                   frame_set, parity_set, overrun_set;

    uart_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (rx_push_q),
        .wdata (rx_byte_q),
        .rd    (rx_rd),
        .rdata (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign rx_sample  = (rx_cnt_q == HALF);
    assign rx_bit_end = (rx_cnt_q == DIV_M1);

    // RX next state; leaving at the stop-bit sample re-arms edge detection for the next frame
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            S_IDLE:   if (!sync2_q && rx_prev_q) rx_state_d = S_START;
            S_START:  if (rx_sample && sync2_q) rx_state_d = S_IDLE;
                      else if (rx_bit_end) rx_state_d = S_DATA;
            S_DATA:   if (rx_bit_end && rx_bit_q == LAST_BIT) rx_state_d = PEN ? S_PARITY : S_STOP;
            S_PARITY: if (rx_bit_end) rx_state_d = S_STOP;
            S_STOP:   if (rx_sample) rx_state_d = S_IDLE;
            default:  rx_state_d = S_IDLE;
        endcase
    end

    // RX datapath: mid-bit sampling, frame/parity checks, staged push, sticky errors
    always_comb begin
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_par_d    = rx_par_q;
        rx_push_d   = 1'b0;
        rx_byte_d   = rx_byte_q;
        frame_set   = 1'b0;
        parity_set  = 1'b0;
        // The detection cycle is the first low cycle of the start bit, so count from 1
        if (rx_state_q == S_IDLE)
            rx_cnt_d = (rx_state_d == S_START) ? 16'd1 : 16'd0;
        else if (rx_state_d == S_IDLE || rx_bit_end)
            rx_cnt_d = 16'd0;
        else
            rx_cnt_d = rx_cnt_q + 16'd1;
        if (rx_state_q == S_IDLE)
            rx_bit_d = 3'd0;
        if (rx_state_q == S_DATA && rx_sample)
            rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_state_q == S_DATA && rx_bit_end)
            rx_bit_d = rx_bit_q + 3'd1;
        if (rx_state_q == S_PARITY && rx_sample)
            rx_par_d = sync2_q;
        if (rx_state_q == S_STOP && rx_sample) begin
            if (!sync2_q)
                frame_set = 1'b1;
            else if (PEN && (rx_par_q != ((^rx_shift_q) ^ ODD)))
                parity_set = 1'b1;
            else begin
                rx_push_d = 1'b1;
                rx_byte_d = rx_shift_q;
            end
        end
        overrun_set = rx_push_q && rx_full;
        err_d       = (err_clr ? 3'b000 : err_q) | {overrun_set, frame_set, parity_set};
    end

    // RX synchroniser, state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_push_q  <= 1'b0;
            rx_byte_q  <= '0;
            err_q      <= 3'b000;
        end else begin
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            rx_prev_q  <= sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_push_q  <= rx_push_d;
            rx_byte_q  <= rx_byte_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
endmodule

// File: tb/tb_uart_fifo.sv
module tb_uart_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic       loop_sel, rx_a_drv, rx_a, rx_b;
    logic       tx_a, tx_b;
    logic [7:0] tx_data_a, tx_data_b, rx_data_a, rx_data_b;
    logic       tx_wr_a, tx_wr_b, tx_full_a, tx_full_b;
    logic       rx_rd_a, rx_rd_b, rx_empty_a, rx_empty_b;
    logic       busy_a, busy_b, err_clr_a, err_clr_b;
    logic [2:0] err_a, err_b;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fa;

    always #5 clk = ~clk;

    assign rx_a = loop_sel ? tx_a : rx_a_drv;

    uart_fifo #(.CLK_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a),
        .tx_data(tx_data_a), .tx_wr(tx_wr_a), .tx_full(tx_full_a),
        .rx_data(rx_data_a), .rx_rd(rx_rd_a), .rx_empty(rx_empty_a),
        .busy(busy_a), .err(err_a), .err_clr(err_clr_a)
    );

    uart_fifo #(.CLK_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .tx(tx_b),
        .tx_data(tx_data_b), .tx_wr(tx_wr_b), .tx_full(tx_full_b),
        .rx_data(rx_data_b), .rx_rd(rx_rd_b), .rx_empty(rx_empty_b),
        .busy(busy_b), .err(err_b), .err_clr(err_clr_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int tgt, input logic v);
        if (tgt == 0) rx_a_drv = v;
        else          rx_b     = v;
    endtask

    task automatic drive_bit(input int tgt, input logic v);
        set_line(tgt, v);
        repeat (4) tick();
    endtask

    task automatic send_frame(input int tgt, input logic [7:0] d, input logic with_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(tgt, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(tgt, d[i]);
        if (with_par) drive_bit(tgt, par_bit);
        drive_bit(tgt, stop_bit);
        set_line(tgt, 1'b1);
        repeat (4) tick();
    endtask

    task automatic tx_write_a(input logic [7:0] d);
        tx_data_a = d;
        tx_wr_a   = 1'b1;
        tick();
        tx_wr_a   = 1'b0;
    endtask

    task automatic pulse_clr_a();
        err_clr_a = 1'b1;
        tick();
        err_clr_a = 1'b0;
    endtask

    // Pop n bytes from the selected RX FIFO, comparing each against the scoreboard
    task automatic drain(input int tgt, input int n, input int budget);
        int got = 0;
        logic [7:0] e;
        for (int c = 0; c < budget && got < n; c++) begin
            if ((tgt == 0 ? rx_empty_a : rx_empty_b) == 1'b0) begin
                e = exp_q.pop_front();
                check("rx_byte", (tgt == 0) ? rx_data_a : rx_data_b, e);
                if (tgt == 0) rx_rd_a = 1'b1; else rx_rd_b = 1'b1;
                tick();
                rx_rd_a = 1'b0;
                rx_rd_b = 1'b0;
                got++;
            end else begin
                tick();
            end
        end
        check("rx_count", got, n);
    endtask

    initial begin
        rst = 1'b1; loop_sel = 1'b0; rx_a_drv = 1'b1; rx_b = 1'b1;
        tx_data_a = '0; tx_data_b = '0; tx_wr_a = 1'b0; tx_wr_b = 1'b0;
        rx_rd_a = 1'b0; rx_rd_b = 1'b0; err_clr_a = 1'b0; err_clr_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_tx", tx_a, 1'b1);
        check("rst_tx_full", tx_full_a, 1'b0);
        check("rst_rx_empty", rx_empty_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_err", err_a, 3'b000);
        check("rst_rx_data", rx_data_a, 8'h00);
        check("rst_tx_b", tx_b, 1'b1);
        check("rst_rx_empty_b", rx_empty_b, 1'b1);
        check("rst_err_b", err_b, 3'b000);
        rst = 1'b0;
        repeat (2) tick();

        // Single TX frame of 0xFA, checked every cycle
        fa = 8'hFA;
        tx_write_a(fa);
        check("tx_pre_start", tx_a, 1'b1);
        check("busy_queued", busy_a, 1'b1);
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                check("tx_bit", tx_a, (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : fa[b-1]);
            end
        end
        tick();
        check("tx_idle_after", tx_a, 1'b1);
        check("busy_after", busy_a, 1'b0);

        // Loopback of three back-to-back frames
        loop_sel = 1'b1;
        tick();
        tx_write_a(8'h55); exp_q.push_back(8'h55);
        tx_write_a(8'hA3); exp_q.push_back(8'hA3);
        tx_write_a(8'h00); exp_q.push_back(8'h00);
        drain(0, 3, 400);
        check("loop_err", err_a, 3'b000);
        repeat (8) tick();
        loop_sel = 1'b0;
        tick();

        // Overrun: depth-4 RX FIFO receives 5 frames with no reads
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1); exp_q.push_back(8'h11);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1); exp_q.push_back(8'h22);
        send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1); exp_q.push_back(8'h33);
        send_frame(0, 8'h44, 1'b0, 1'b0, 1'b1); exp_q.push_back(8'h44);
        check("err_before_ovr", err_a, 3'b000);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        check("err_overrun", err_a, 3'b100);
        drain(0, 4, 20);
        check("rx_empty_after_ovr", rx_empty_a, 1'b1);
        pulse_clr_a();
        check("err_cleared", err_a, 3'b000);

        // Stop bit sampled low
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        check("err_frame", err_a, 3'b010);
        check("frame_nothing_stored", rx_empty_a, 1'b1);
        pulse_clr_a();
        check("err_cleared2", err_a, 3'b000);

        // Two-cycle glitch on idle line
        rx_a_drv = 1'b0;
        repeat (2) tick();
        rx_a_drv = 1'b1;
        repeat (20) tick();
        check("glitch_no_byte", rx_empty_a, 1'b1);
        check("glitch_no_err", err_a, 3'b000);

        // Even parity: 0x01 needs parity 1, send 0
        send_frame(1, 8'h01, 1'b1, 1'b0, 1'b1);
        check("err_parity", err_b, 3'b001);
        check("parity_nothing_stored", rx_empty_b, 1'b1);
        send_frame(1, 8'hA5, 1'b1, 1'b0, 1'b1); exp_q.push_back(8'hA5);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1); exp_q.push_back(8'h07);
        drain(1, 2, 20);
        check("parity_sticky", err_b, 3'b001);

        // Reset during TX DATA with queued bytes, a stored RX byte and an error flag
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("pre_rst_err", err_a, 3'b010);
        check("pre_rst_rx_empty", rx_empty_a, 1'b0);
        for (int i = 0; i < 6; i++) tx_write_a(8'h00);
        check("tx_full", tx_full_a, 1'b1);
        repeat (3) tick();
        check("pre_rst_tx_data_bit", tx_a, 1'b0);
        check("pre_rst_busy", busy_a, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", tx_a, 1'b1);
        check("mid_rst_tx_full", tx_full_a, 1'b0);
        check("mid_rst_rx_empty", rx_empty_a, 1'b1);
        check("mid_rst_err", err_a, 3'b000);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_rx_data", rx_data_a, 8'h00);
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        check("post_rst_tx", tx_a, 1'b1);
        check("post_rst_busy", busy_a, 1'b0);
        check("post_rst_rx_empty", rx_empty_a, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
